// File: rtl/pwm_hall_pkg.sv
// Shared constants and helpers for the PWM-driven hall sensor emulator.
package pwm_hall_pkg;

  localparam int HALL_STEPS          = 6;
  localparam int HALL_IDX_W          = 3;
  localparam int SYNC_STAGES_DEFAULT = 2;

  localparam logic [HALL_IDX_W-1:0] HALL_RESET_IDX = 3'd0;
  localparam logic [HALL_IDX_W-1:0] HALL_LAST_IDX  = 3'd5;

  // Hall pattern table {C,B,A}; entry 0 is the rightmost element.
  localparam logic [HALL_STEPS-1:0][2:0] HALL_TABLE = {
    3'b001,  // 5
    3'b011,  // 4
    3'b010,  // 3
    3'b110,  // 2
    3'b100,  // 1
    3'b101   // 0
  };

  // Sensor pattern for a hall index; out-of-range indices map to entry 0.
  function automatic logic [2:0] hall_pattern(input logic [HALL_IDX_W-1:0] idx);
    if (idx > HALL_LAST_IDX) begin
      return HALL_TABLE[HALL_RESET_IDX];
    end
    return HALL_TABLE[idx];
  endfunction

  // Next hall index: dir = 0 walks upward (5 -> 0), dir = 1 downward (0 -> 5).
  function automatic logic [HALL_IDX_W-1:0] hall_next(input logic [HALL_IDX_W-1:0] idx,
                                                      input logic dir);
    if (dir) begin
      return (idx == 3'd0) ? HALL_LAST_IDX : idx - 3'd1;
    end
    return (idx >= HALL_LAST_IDX) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/pwm_hall_core_duty_meter.sv
// Windowed duty measurement of an asynchronous PWM input:
// synchronizer, window counter, high-cycle counter and lost-PWM detection.
module pwm_duty_meter
  import pwm_hall_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             pwm_in,
  input  logic [CNT_W-1:0] cfg_window,
  output logic [CNT_W-1:0] duty_meas,
  output logic             duty_valid,
  output logic             pwm_lost
);

  // Depths below two are not allowed; clamp rather than build a 1-flop sync.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] MIN_WIN = CNT_W'(2);

  logic [SYNC_N-1:0] sync_q;
  logic              pwm_s;
  logic              pwm_s_d;
  logic              pwm_edge;
  logic              edge_seen;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  win_last;
  logic [CNT_W-1:0]  win_eff;
  logic [CNT_W-1:0]  hi_cnt;
  logic [CNT_W-1:0]  hi_total;
  logic              wrap;

  assign pwm_s    = sync_q[SYNC_N-1];
  assign pwm_edge = pwm_s ^ pwm_s_d;
  assign win_eff  = (cfg_window < MIN_WIN) ? MIN_WIN : cfg_window;
  assign wrap     = (win_cnt == win_last);
  // High count including the current (possibly wrap) cycle.
  assign hi_total = hi_cnt + {{(CNT_W-1){1'b0}}, pwm_s};

  // Metastability synchronizer; only its last stage feeds any logic.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_N-2:0], pwm_in};
    end
  end

  // Window counter; the window length is re-sampled only at the wrap.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      win_cnt  <= '0;
      win_last <= win_eff - CNT_W'(1);
    end else if (wrap) begin
      win_cnt  <= '0;
      win_last <= win_eff - CNT_W'(1);
    end else begin
      win_cnt  <= win_cnt + CNT_W'(1);
    end
  end

  // High-cycle counter, published to duty_meas at each wrap.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hi_cnt     <= '0;
      duty_meas  <= '0;
      duty_valid <= 1'b0;
    end else begin
      duty_valid <= wrap;
      if (wrap) begin
        hi_cnt    <= '0;
        duty_meas <= hi_total;
      end else begin
        hi_cnt    <= hi_total;
      end
    end
  end

  // Edge flag per window; a window with no transition reports lost PWM.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pwm_s_d   <= 1'b0;
      edge_seen <= 1'b0;
      pwm_lost  <= 1'b0;
    end else begin
      pwm_s_d <= pwm_s;
      if (wrap) begin
        pwm_lost  <= ~(edge_seen | pwm_edge);
        edge_seen <= 1'b0;
      end else if (pwm_edge) begin
        edge_seen <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_hall_core.sv
// Hall sensor emulator: converts measured PWM duty into a hall step rate
// by accumulating duty_meas against a per-step threshold (no divider).
module pwm_hall_core
  import pwm_hall_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             pwm_in,
  input  logic             cfg_enable,
  input  logic             cfg_dir,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [31:0]      cfg_step_thresh,
  output logic [2:0]       hall_out,
  output logic [CNT_W-1:0] duty_meas,
  output logic             duty_valid,
  output logic             step_pulse,
  output logic             pwm_lost
);

  logic [32:0]           acc;
  logic [32:0]           acc_sum;
  logic [32:0]           duty_ext;
  logic [32:0]           thresh_ext;
  logic                  acc_run;
  logic                  step_go;
  logic [HALL_IDX_W-1:0] hall_idx;
  logic [HALL_IDX_W-1:0] hall_idx_nxt;

  pwm_duty_meter #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_duty_meter (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .pwm_in     (pwm_in),
    .cfg_window (cfg_window),
    .duty_meas  (duty_meas),
    .duty_valid (duty_valid),
    .pwm_lost   (pwm_lost)
  );

  assign duty_ext     = {{(33-CNT_W){1'b0}}, duty_meas};
  assign thresh_ext   = {1'b0, cfg_step_thresh};
  assign hall_idx_nxt = hall_next(hall_idx, cfg_dir);

  // Step decision: at most one step per cycle, residue carried in acc.
  always_comb begin
    acc_run = cfg_enable && (cfg_step_thresh != 32'd0) && (duty_meas != '0);
    acc_sum = acc + duty_ext;
    step_go = acc_run && (acc_sum >= thresh_ext);
  end

  // Phase accumulator; cleared while disabled, held when idle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      acc <= '0;
    end else if (!cfg_enable) begin
      acc <= '0;
    end else if (acc_run) begin
      acc <= step_go ? (acc_sum - thresh_ext) : acc_sum;
    end
  end

  // Hall sequencer; hall_out and step_pulse update in the same cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      hall_idx   <= HALL_RESET_IDX;
      hall_out   <= hall_pattern(HALL_RESET_IDX);
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= step_go;
      if (step_go) begin
        hall_idx <= hall_idx_nxt;
        hall_out <= hall_pattern(hall_idx_nxt);
      end
    end
  end

endmodule

// File: tb/tb_pwm_hall_core.sv
// Self-checking bench for pwm_hall_core: directed vector table, hand-written
// stepping sequences and a randomized phase against a behavioural model.
module tb_pwm_hall_core;

  localparam int  CNT_W  = 16;
  localparam int  SYNC   = 2;
  localparam longint MASK33 = (64'd1 << 33) - 1;

  // ---------------- clock / reset ----------------
  logic tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  logic             ARESET;
  logic             pwm_in;
  logic             cfg_enable;
  logic             cfg_dir;
  logic [CNT_W-1:0] cfg_window;
  logic [31:0]      cfg_step_thresh;
  logic [2:0]       hall_out;
  logic [CNT_W-1:0] duty_meas;
  logic             duty_valid;
  logic             step_pulse;
  logic             pwm_lost;

  pwm_hall_core #(
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC)
  ) dut (
    .ACLK            (tb_ACLK),
    .ARESET          (ARESET),
    .pwm_in          (pwm_in),
    .cfg_enable      (cfg_enable),
    .cfg_dir         (cfg_dir),
    .cfg_window      (cfg_window),
    .cfg_step_thresh (cfg_step_thresh),
    .hall_out        (hall_out),
    .duty_meas       (duty_meas),
    .duty_valid      (duty_valid),
    .step_pulse      (step_pulse),
    .pwm_lost        (pwm_lost)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [2:0] hall_tab [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

  bit     m_pipe[$];   // newest pwm_in at front, pwm_s at back
  bit     m_win[$];    // pwm_s samples of the window in progress
  bit     m_prev_s;    // last pwm_s of the previous window
  int     m_wl;
  int     m_duty;
  bit     m_valid;
  bit     m_lost;
  longint m_acc;
  int     m_idx;
  bit     m_step;

  function automatic int eff_win(input int w);
    return (w < 2) ? 2 : w;
  endfunction

  task automatic model_reset();
    m_pipe.delete();
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
    m_win.delete();
    m_prev_s = 1'b0;
    m_wl     = eff_win(int'(cfg_window));
    m_duty   = 0;
    m_valid  = 1'b0;
    m_lost   = 1'b0;
    m_acc    = 0;
    m_idx    = 0;
    m_step   = 1'b0;
  endtask

  task automatic model_step();
    bit     cur_s;
    int     ones;
    bit     changed;
    longint s;
    cur_s = m_pipe[m_pipe.size()-1];
    // stepping uses the duty value that was published before this edge
    m_step = 1'b0;
    if (!cfg_enable) begin
      m_acc = 0;
    end else if (cfg_step_thresh != 0 && m_duty != 0) begin
      s = (m_acc + m_duty) & MASK33;
      if (s >= longint'(cfg_step_thresh)) begin
        m_acc  = (s - longint'(cfg_step_thresh)) & MASK33;
        m_idx  = cfg_dir ? (m_idx + 5) % 6 : (m_idx + 1) % 6;
        m_step = 1'b1;
      end else begin
        m_acc = s;
      end
    end
    // measurement window
    m_valid = 1'b0;
    m_win.push_back(cur_s);
    if (m_win.size() == m_wl) begin
      ones    = 0;
      changed = (m_win[0] != m_prev_s);
      for (int i = 0; i < m_win.size(); i++) begin
        ones += int'(m_win[i]);
        if (i > 0 && m_win[i] != m_win[i-1]) changed = 1'b1;
      end
      m_duty   = ones;
      m_lost   = !changed;
      m_valid  = 1'b1;
      m_prev_s = m_win[m_win.size()-1];
      m_win.delete();
      m_wl     = eff_win(int'(cfg_window));
    end
    // synchronizer delay line
    m_pipe.push_front(pwm_in);
    void'(m_pipe.pop_back());
  endtask

  // ---------------- pwm stimulus generator ----------------
  int hi_len  = 25;
  int lo_len  = 75;
  int ph      = 0;
  bit rnd_pwm = 1'b0;

  task automatic pwm_gen();
    if (rnd_pwm) begin
      pwm_in = ($urandom_range(0, 3) == 0) ? ~pwm_in : pwm_in;
    end else begin
      ph     = (ph + 1) % (hi_len + lo_len);
      pwm_in = (ph < hi_len);
    end
  endtask

  // One clock: advance model at the edge, compare #1 later, drive next pwm.
  task automatic cycle();
    @(posedge tb_ACLK);
    if (ARESET) model_reset();
    else        model_step();
    #1;
    check("m_hall_out",   hall_out,   m_step ? hall_tab[m_idx] : hall_tab[m_idx]);
    check("m_duty_meas",  duty_meas,  m_duty);
    check("m_duty_valid", duty_valid, m_valid);
    check("m_step_pulse", step_pulse, m_step);
    check("m_pwm_lost",   pwm_lost,   m_lost);
    pwm_gen();
  endtask

  // ---------------- driver helpers ----------------
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!duty_valid && n < budget);
    if (!duty_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: no duty_valid within %0d cycles", budget);
    end
  endtask

  task automatic wait_step(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_pulse && n < budget);
    if (!step_pulse) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_step: no step_pulse within %0d cycles", budget);
    end
  endtask

  // ---------------- directed measurement vectors ----------------
  typedef struct {
    int win;
    int hi;
    int lo;
    int exp_duty;
    bit exp_lost;
  } meas_vec_t;

  meas_vec_t vecs [7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit [2:0] rev_seq [4];

    vecs[0] = '{win: 100, hi: 25, lo: 75, exp_duty: 25,  exp_lost: 1'b0};
    vecs[1] = '{win: 100, hi: 50, lo: 50, exp_duty: 50,  exp_lost: 1'b0};
    vecs[2] = '{win: 64,  hi: 16, lo: 16, exp_duty: 32,  exp_lost: 1'b0};
    vecs[3] = '{win: 0,   hi: 1,  lo: 1,  exp_duty: 1,   exp_lost: 1'b0};
    vecs[4] = '{win: 100, hi: 0,  lo: 1,  exp_duty: 0,   exp_lost: 1'b1};
    vecs[5] = '{win: 100, hi: 1,  lo: 0,  exp_duty: 100, exp_lost: 1'b1};
    vecs[6] = '{win: 100, hi: 25, lo: 75, exp_duty: 25,  exp_lost: 1'b0};
    rev_seq = '{3'b110, 3'b100, 3'b101, 3'b001};

    ARESET          = 1'b1;
    pwm_in          = 1'b0;
    cfg_enable      = 1'b0;
    cfg_dir         = 1'b0;
    cfg_window      = 16'd100;
    cfg_step_thresh = 32'd0;
    model_reset();

    // reset held for 5 cycles
    repeat (5) cycle();
    ARESET = 1'b0;
    check("rst_hall_out",   hall_out,   3'b101);
    check("rst_duty_meas",  duty_meas,  0);
    check("rst_duty_valid", duty_valid, 0);
    check("rst_step_pulse", step_pulse, 0);
    check("rst_pwm_lost",   pwm_lost,   0);
    wait_valid(400, n);
    check("first_valid_latency", n, 100);

    // measurement table: three windows per row, then compare
    for (int v = 0; v < 7; v++) begin
      cfg_window = CNT_W'(vecs[v].win);
      hi_len     = vecs[v].hi;
      lo_len     = vecs[v].lo;
      ph         = 0;
      wait_valid(1000, n);
      wait_valid(1000, n);
      wait_valid(1000, n);
      check($sformatf("vec%0d_period", v),   n,         eff_win(vecs[v].win));
      check($sformatf("vec%0d_duty", v),     duty_meas, vecs[v].exp_duty);
      check($sformatf("vec%0d_pwm_lost", v), pwm_lost,  vecs[v].exp_lost);
    end

    // forward stepping: duty 25, thresh 1000 -> one step per 40 cycles
    cfg_step_thresh = 32'd1000;
    cfg_dir         = 1'b0;
    cfg_enable      = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_step(200, n);
      check($sformatf("fwd%0d_period", k), n,        40);
      check($sformatf("fwd%0d_hall", k),   hall_out, hall_tab[(k + 1) % 6]);
    end

    // reversal from index 3 (010)
    cfg_dir = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_step(200, n);
      check($sformatf("rev%0d_period", k), n,        40);
      check($sformatf("rev%0d_hall", k),   hall_out, rev_seq[k]);
    end

    // disable: frozen hall, no pulses; re-enable resumes with a cleared acc
    cfg_enable = 1'b0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (k % 10 == 0) begin
        check("dis_step_pulse", step_pulse, 0);
        check("dis_hall_frozen", hall_out, 3'b001);
      end
    end
    cfg_enable = 1'b1;
    wait_step(200, n);
    check("reen_period", n,        40);
    check("reen_hall",   hall_out, 3'b011);

    // threshold 1 -> one step every cycle from index 4
    cfg_step_thresh = 32'd1;
    cfg_dir         = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      check("t1_step_pulse", step_pulse, 1);
      check("t1_hall",       hall_out,   hall_tab[(4 + k + 1) % 6]);
    end

    // reset mid-window discards the partial measurement
    cfg_step_thresh = 32'd1000;
    repeat (37) cycle();
    ARESET = 1'b1;
    cycle();
    ARESET = 1'b0;
    check("mid_rst_hall", hall_out,  3'b101);
    check("mid_rst_duty", duty_meas, 0);
    wait_valid(400, n);
    check("mid_rst_latency", n, 100);

    // randomized segments checked against the model every cycle
    for (int seg = 0; seg < 60; seg++) begin
      cfg_window      = CNT_W'($urandom_range(0, 40));
      hi_len          = $urandom_range(0, 20);
      lo_len          = $urandom_range(0, 20);
      if (hi_len + lo_len == 0) lo_len = 1;
      ph              = 0;
      rnd_pwm         = ($urandom_range(0, 4) == 0);
      cfg_step_thresh = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 400));
      cfg_enable      = ($urandom_range(0, 4) != 0);
      cfg_dir         = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 14) == 0) begin
        ARESET = 1'b1;
        cycle();
        ARESET = 1'b0;
      end
      repeat ($urandom_range(20, 120)) begin
        cycle();
        if ($urandom_range(0, 29) == 0) cfg_dir = ~cfg_dir;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
